// File: rtl/scariv_pred_ras.sv
// scariv_pred_ras
// ----------------------------------------------------------------------------
// Return address stack for the front-end predictor. It sits beside the
// gshare/BTB logic in the fetch stage, consumes decoded call/return hints and
// is restored from a checkpoint by the branch-resolution path.
//
// Parameters:
//   ENTRY_SIZE : stack depth, power of two, >= 2
//   ADDR_W     : return-address width
//   PTR_W      : derived pointer width, not meant to be overridden
//
// Ports:
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_push_valid/i_push_addr : call detected, push the return address
//   i_pop_valid              : return detected, pop
//   i_recover_valid/_ptr/_cnt: misprediction restore of tos and occupancy
//   i_recover_top_addr       : checkpointed top entry (macro only)
//   o_top_valid/o_top_addr   : predicted return target, valid when cnt != 0
//   o_ckpt_ptr/o_ckpt_cnt    : current tos/occupancy for branch snapshots
//   o_ckpt_top_addr          : current top entry (macro only)
//   o_overflow/o_underflow   : registered one-cycle event pulses
//
// Handshake: every request input is a one-cycle valid strobe with no ready;
// the stack accepts one operation per cycle and never back-pressures.
//
// Configuration: define SCARIV_RAS_TOP_RESTORE_EN to add the top-entry
// checkpoint ports; recovery then also rewrites mem[i_recover_ptr].
// ----------------------------------------------------------------------------
module scariv_pred_ras #(
    parameter int ENTRY_SIZE = 16,
    parameter int ADDR_W     = 39,
    parameter int PTR_W      = $clog2(ENTRY_SIZE)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push_valid,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic              i_pop_valid,
    input  logic              i_recover_valid,
    input  logic [PTR_W-1:0]  i_recover_ptr,
    input  logic [PTR_W:0]    i_recover_cnt,
`ifdef SCARIV_RAS_TOP_RESTORE_EN
    input  logic [ADDR_W-1:0] i_recover_top_addr,
    output logic [ADDR_W-1:0] o_ckpt_top_addr,
`endif
    output logic              o_top_valid,
    output logic [ADDR_W-1:0] o_top_addr,
    output logic [PTR_W-1:0]  o_ckpt_ptr,
    output logic [PTR_W:0]    o_ckpt_cnt,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(ENTRY_SIZE);
    localparam logic [PTR_W-1:0] TOS_INIT = PTR_W'(ENTRY_SIZE - 1);

    logic [ADDR_W-1:0] mem [ENTRY_SIZE];
    logic [PTR_W-1:0]  tos;
    logic [PTR_W:0]    cnt;
    logic              overflow;
    logic              underflow;

    // Pointer arithmetic wraps naturally in PTR_W bits since depth is 2^PTR_W.
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] tos_dec;
    logic             stack_empty;
    logic [PTR_W:0]   recover_cnt_clamped;

    always_comb begin
        tos_inc             = tos + 1'b1;
        tos_dec             = tos - 1'b1;
        stack_empty         = (cnt == '0);
        // Out-of-range checkpoints are illegal; saturate rather than corrupt.
        recover_cnt_clamped = (i_recover_cnt > CNT_FULL) ? CNT_FULL : i_recover_cnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tos       <= TOS_INIT;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (i_recover_valid) begin
                // Recovery wins over any same-cycle push/pop from the wrong path.
                tos <= i_recover_ptr;
                cnt <= recover_cnt_clamped;
`ifdef SCARIV_RAS_TOP_RESTORE_EN
                mem[i_recover_ptr] <= i_recover_top_addr;
`endif
            end else if (i_push_valid && i_pop_valid && !stack_empty) begin
                // Call and return together: replace the top in place.
                mem[tos] <= i_push_addr;
            end else if (i_push_valid) begin
                tos          <= tos_inc;
                mem[tos_inc] <= i_push_addr;
                if (cnt == CNT_FULL) begin
                    // Oldest entry is overwritten; occupancy stays saturated.
                    overflow <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (i_pop_valid) begin
                if (stack_empty) begin
                    underflow <= 1'b1;
                end else begin
                    tos <= tos_dec;
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_top_valid = !stack_empty;
        o_top_addr  = mem[tos];
        o_ckpt_ptr  = tos;
        o_ckpt_cnt  = cnt;
        o_overflow  = overflow;
        o_underflow = underflow;
`ifdef SCARIV_RAS_TOP_RESTORE_EN
        o_ckpt_top_addr = mem[tos];
`endif
    end

endmodule

// File: tb/tb_scariv_pred_ras.sv
module tb_scariv_pred_ras;

    localparam int N  = 16;
    localparam int AW = 39;
    localparam int PW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          push_v;
    logic [AW-1:0] push_a;
    logic          pop_v;
    logic          rec_v;
    logic [PW-1:0] rec_ptr;
    logic [PW:0]   rec_cnt;
    logic [AW-1:0] rec_top;
    logic          top_valid;
    logic [AW-1:0] top_addr;
    logic [PW-1:0] ckpt_ptr;
    logic [PW:0]   ckpt_cnt;
    logic          ovf;
    logic          unf;
`ifdef SCARIV_RAS_TOP_RESTORE_EN
    logic [AW-1:0] ckpt_top;
`endif

    scariv_pred_ras #(.ENTRY_SIZE(N), .ADDR_W(AW)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_push_valid       (push_v),
        .i_push_addr        (push_a),
        .i_pop_valid        (pop_v),
        .i_recover_valid    (rec_v),
        .i_recover_ptr      (rec_ptr),
        .i_recover_cnt      (rec_cnt),
`ifdef SCARIV_RAS_TOP_RESTORE_EN
        .i_recover_top_addr (rec_top),
        .o_ckpt_top_addr    (ckpt_top),
`endif
        .o_top_valid        (top_valid),
        .o_top_addr         (top_addr),
        .o_ckpt_ptr         (ckpt_ptr),
        .o_ckpt_cnt         (ckpt_cnt),
        .o_overflow         (ovf),
        .o_underflow        (unf)
    );

    // ---------------- reference model ----------------
    logic [AW-1:0] m_mem [N];
    int            m_tos;
    int            m_cnt;
    bit            m_ovf;
    bit            m_unf;

    task automatic model_step(input bit r, input bit pu, input bit po, input logic [AW-1:0] a,
                              input bit rv, input int rp, input int rc, input logic [AW-1:0] rt);
        if (r) begin
            for (int i = 0; i < N; i++) m_mem[i] = '0;
            m_tos = N - 1;
            m_cnt = 0;
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        m_ovf = 0;
        m_unf = 0;
        if (rv) begin
            m_tos = rp % N;
            m_cnt = (rc > N) ? N : rc;
`ifdef SCARIV_RAS_TOP_RESTORE_EN
            m_mem[rp % N] = rt;
`endif
        end else if (pu && po && m_cnt > 0) begin
            m_mem[m_tos] = a;
        end else if (pu) begin
            m_tos = (m_tos + 1) % N;
            m_mem[m_tos] = a;
            if (m_cnt == N) m_ovf = 1;
            else m_cnt++;
        end else if (po) begin
            if (m_cnt == 0) m_unf = 1;
            else begin
                m_tos = (m_tos + N - 1) % N;
                m_cnt--;
            end
        end
    endtask

    // ---------------- scoreboard / checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".top_valid"}, 64'(top_valid), 64'(m_cnt != 0));
        check({tag, ".top_addr"},  64'(top_addr),  64'(m_mem[m_tos]));
        check({tag, ".ckpt_ptr"},  64'(ckpt_ptr),  64'(m_tos));
        check({tag, ".ckpt_cnt"},  64'(ckpt_cnt),  64'(m_cnt));
        check({tag, ".overflow"},  64'(ovf),       64'(m_ovf));
        check({tag, ".underflow"}, 64'(unf),       64'(m_unf));
`ifdef SCARIV_RAS_TOP_RESTORE_EN
        check({tag, ".ckpt_top"},  64'(ckpt_top),  64'(m_mem[m_tos]));
`endif
    endtask

    // ---------------- driver ----------------
    task automatic do_op(input string tag, input bit r, input bit pu, input bit po,
                         input logic [AW-1:0] a, input bit rv, input int rp, input int rc,
                         input logic [AW-1:0] rt);
        logic [31:0] rp32;
        logic [31:0] rc32;
        rp32    = rp;
        rc32    = rc;
        rst     = r;
        push_v  = pu;
        push_a  = a;
        pop_v   = po;
        rec_v   = rv;
        rec_ptr = rp32[PW-1:0];
        rec_cnt = rc32[PW:0];
        rec_top = rt;
        @(posedge clk);
        model_step(r, pu, po, a, rv, rp, rc, rt);
        #1;
        rst = 0; push_v = 0; pop_v = 0; rec_v = 0;
        check_all(tag);
    endtask

    task automatic do_reset();  do_op("reset", 1, 0, 0, '0, 0, 0, 0, '0); endtask
    task automatic do_push(input logic [AW-1:0] a); do_op("push", 0, 1, 0, a, 0, 0, 0, '0); endtask
    task automatic do_pop();    do_op("pop", 0, 0, 1, '0, 0, 0, 0, '0); endtask
    task automatic do_pp(input logic [AW-1:0] a);   do_op("pushpop", 0, 1, 1, a, 0, 0, 0, '0); endtask

    initial begin
        rst = 1; push_v = 0; push_a = '0; pop_v = 0; rec_v = 0;
        rec_ptr = '0; rec_cnt = '0; rec_top = '0;

        // Reset then three pushes / three pops.
        do_reset();
        check("rst.top_valid_lit", 64'(top_valid), 64'd0);
        check("rst.ckpt_ptr_lit",  64'(ckpt_ptr),  64'd15);
        do_push(39'h1000);
        do_push(39'h2000);
        do_push(39'h3000);
        check("p3.top_lit", 64'(top_addr), 64'h3000);
        check("p3.ptr_lit", 64'(ckpt_ptr), 64'd2);
        check("p3.cnt_lit", 64'(ckpt_cnt), 64'd3);
        do_pop();
        check("pop1.top_lit", 64'(top_addr), 64'h2000);
        do_pop();
        check("pop2.top_lit", 64'(top_addr), 64'h1000);
        do_pop();
        check("pop3.valid_lit", 64'(top_valid), 64'd0);

        // Overflow wrap and drain to underflow.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            do_push(39'(k * 'h100));
            if (k < 17) check("ovf.early_lit", 64'(ovf), 64'd0);
        end
        check("ovf.pulse_lit", 64'(ovf), 64'd1);
        check("ovf.cnt_lit", 64'(ckpt_cnt), 64'd16);
        check("ovf.top_lit", 64'(top_addr), 64'h1100);
        do_pop();
        check("ovf.pulse_gone_lit", 64'(ovf), 64'd0);
        check("ovf.pop1_lit", 64'(top_addr), 64'h1000);
        for (int k = 2; k <= 16; k++) do_pop();
        check("drain.valid_lit", 64'(top_valid), 64'd0);
        do_pop();
        check("unf.pulse_lit", 64'(unf), 64'd1);
        do_op("idle", 0, 0, 0, '0, 0, 0, 0, '0);
        check("unf.gone_lit", 64'(unf), 64'd0);

        // Same-cycle call+return.
        do_reset();
        do_push(39'hA0);
        do_push(39'hB0);
        do_pp(39'hC0);
        check("pp.top_lit", 64'(top_addr), 64'hC0);
        check("pp.cnt_lit", 64'(ckpt_cnt), 64'd2);
        do_pop();
        check("pp.next_lit", 64'(top_addr), 64'hA0);
        do_reset();
        do_pp(39'hC0);
        check("pp_empty.cnt_lit", 64'(ckpt_cnt), 64'd1);
        check("pp_empty.top_lit", 64'(top_addr), 64'hC0);

        // Recovery after wrong-path overwrite of the top entry.
        do_reset();
        do_push(39'hA0);
        do_push(39'hB0);
        do_pp(39'hD0);
        do_op("recover", 0, 0, 0, '0, 1, 1, 2, 39'hB0);
        check("rec.ptr_lit", 64'(ckpt_ptr), 64'd1);
        check("rec.cnt_lit", 64'(ckpt_cnt), 64'd2);
`ifdef SCARIV_RAS_TOP_RESTORE_EN
        check("rec.top_lit", 64'(top_addr), 64'hB0);
`else
        check("rec.top_lit", 64'(top_addr), 64'hD0);
`endif

        // Recover together with a push: push dropped, no pulses.
        do_op("rec_push", 0, 1, 0, 39'hE0, 1, 0, 1, 39'hA0);
        check("recpush.ptr_lit", 64'(ckpt_ptr), 64'd0);
        check("recpush.cnt_lit", 64'(ckpt_cnt), 64'd1);
        check("recpush.ovf_lit", 64'(ovf | unf), 64'd0);

        // Recovery count clamp.
        do_op("rec_clamp", 0, 0, 0, '0, 1, 3, 20, 39'h55);
        check("clamp.cnt_lit", 64'(ckpt_cnt), 64'd16);

        // Reset mid-stream wins over a push.
        do_reset();
        for (int k = 0; k < 5; k++) do_push(39'(k + 1));
        do_op("rst_push", 1, 1, 0, 39'hF0, 0, 0, 0, '0);
        check("rstmid.cnt_lit", 64'(ckpt_cnt), 64'd0);
        check("rstmid.top_lit", 64'(top_addr), 64'd0);
        check("rstmid.ptr_lit", 64'(ckpt_ptr), 64'd15);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            bit            r, pu, po, rv;
            int            rp, rc;
            logic [AW-1:0] a, rt;
            r  = ($urandom_range(0, 99) == 0);
            rv = ($urandom_range(0, 9) == 0);
            pu = $urandom_range(0, 1);
            po = $urandom_range(0, 1);
            a  = {$urandom, $urandom};
            rt = {$urandom, $urandom};
            rp = $urandom_range(0, N - 1);
            rc = ($urandom_range(0, 19) == 0) ? $urandom_range(N + 1, 31) : $urandom_range(0, N);
            do_op("rand", r, pu, po, a, rv, rp, rc, rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
